multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Sequencing control unit for the multi-cycle CORG datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Memory accesses use a request/ready handshake with a bounded wait. The unit detects illegal opcodes and memory timeouts. It drives the PC, IR, register-file, ALU and memory-port enables of the shared datapath.

## Interface
Parameters:
- OPCODE_W, 5: opcode width. Must be ≥5; only the low 5 bits are decoded, and any upper bit set marks the opcode illegal.
- ALU_OP_W, 3: alu_op width. Must be ≥3; codes are zero-extended.
- WAIT_LIMIT, 15: maximum cycles spent waiting for mem_ready in FETCH or MEM. 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1: 1 sends an illegal opcode to TRAP; 0 retires it as a NOP.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- opcode, input, OPCODE_W: opcode field from the IR. Stable from DECODE until the next FETCH.
- zero, input, 1: ALU zero flag.
- mem_ready, input, 1: memory completes the current request this cycle.
- mem_req, output, 1: memory request.
- mem_we, output, 1: memory write (store).
- iord, output, 1: memory address source. 0 = PC, 1 = ALU result register.
- ir_write, output, 1: load IR.
- pc_write, output, 1: load PC.
- pc_src, output, 2: PC source. 00 = PC+1, 01 = branch target, 10 = jump target, 11 = rs register.
- reg_dst, output, 1: destination register select. 1 = rd, 0 = rt.
- alu_src, output, 1: ALU operand B select. 1 = immediate.
- alu_op, output, ALU_OP_W: ALU operation.
- reg_write, output, 1: register-file write enable.
- mem_to_reg, output, 1: write-back source. 1 = memory data.
- link, output, 1: write PC+1 into the link register (jal).
- illegal, output, 1: sticky trap flag, cause is illegal opcode.
- timeout, output, 1: sticky trap flag, cause is memory timeout.
- state, output, 3: current state, for debug.

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, WB=3, BRANCH=4, ADDR=5, MEM=6, TRAP=7.
- Opcode map:
  - R-type: add 00000, and 00100, sub 01000, or 01100, xor 10000, sll 11000, srl 11100, jr 10101.
  - I-type: addi 00010, andi 00110, subi 01010, ori 01110, beq 10010, bne 10110, lw 11010, sw 11110.
  - J-type: j 00001, jal 00101.
  - Every other code is illegal.
- alu_op codes:
  - add/addi/ADDR 000, and 001, sub/subi/BRANCH compare 010, or 011, xor 100, sll 110, srl 111.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
- DECODE:
  - j: pc_write=1, pc_src=10, next FETCH.
  - jal: as j, plus reg_write=1 and link=1, next FETCH.
  - jr: pc_write=1, pc_src=11, no register write, next FETCH.
  - ALU R-type and ALU I-type: next EXEC.
  - beq/bne: next BRANCH.
  - lw/sw: next ADDR.
  - Illegal opcode: next TRAP if TRAP_ON_ILLEGAL=1, else FETCH.
- EXEC: alu_op per opcode; alu_src=1 for I-type; next WB.
- WB:
  - reg_write=1.
  - reg_dst=1 for R-type, 0 for I-type and lw.
  - mem_to_reg=1 only for lw.
  - Next FETCH.
- BRANCH:
  - alu_op=010.
  - pc_write = zero for beq, !zero for bne; pc_src=01.
  - Next FETCH.
- ADDR: alu_op=000, alu_src=1, next MEM.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for sw.
  - On mem_ready: sw goes to FETCH; lw goes to WB.
- TRAP: all enables 0; the state is held until rst.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle that mem_req=1 and mem_ready=0.
  - Width is clog2(WAIT_LIMIT+1).
  - When the count equals WAIT_LIMIT and mem_ready=0: next state TRAP, timeout is set, mem_req drops the next cycle.
  - mem_ready takes priority over the timeout in the same cycle.
- Any output not listed for a state is 0.

## Timing
- rst asserts asynchronously: state goes to FETCH, the counter clears, illegal and timeout clear.
- While rst=1, all outputs are 0 and state=0.
- The first mem_req appears in the first cycle after rst deasserts.
- Outputs are decoded combinationally from the state register and opcode. The Mealy exceptions are:
  - ir_write and pc_write in FETCH depend on mem_ready.
  - pc_write in BRANCH depends on zero.
  - mem_we and mem_req are never gated by mem_ready.
- Latency with zero memory wait:
  - jumps 2 cycles; ALU ops 4; branches 3; sw 4; lw 5.
  - Each wait cycle adds 1.
- rst asserted mid-MEM drops mem_req immediately; memory must tolerate an abandoned request.

## Structure
- Shared package cu_pkg holds:
  - opcode constants;
  - alu_op constants;
  - state enum;
  - pc_src constants;
  - an is_rtype/is_itype classification function.
- One sub-module, mem_wait_timer: counter, clear, enable, expired flag, parametrised by WAIT_LIMIT.

## Test plan
- Run add with mem_ready tied to 1 → state sequence 0,1,2,3,0; reg_write=1 and reg_dst=1 in cycle 4; alu_op=000 in EXEC.
- Run lw with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with iord=1; WB asserts mem_to_reg=1; total 8 cycles.
- Run beq with zero=1, then bne with zero=1 → pc_write=1 with pc_src=01 for the first; pc_write=0 for the second.
- Run jal → in DECODE, pc_write=1, pc_src=10, reg_write=1 and link=1; next state FETCH.
- Present opcode 00011 → with TRAP_ON_ILLEGAL=1: state 7, illegal=1, held until rst. With TRAP_ON_ILLEGAL=0: back to FETCH, no enables asserted.
- With WAIT_LIMIT=4 and mem_ready=0 in FETCH → TRAP after 4 wait cycles, timeout=1. Then assert rst mid-wait → all outputs 0 immediately, flags cleared.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the CORG multi-cycle control unit: opcode and ALU codes,
// FSM state encoding, PC source selects and the control-word layout.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_ADDR   = 3'd5,
    S_MEM    = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b10000;
  localparam logic [4:0] OP_SLL  = 5'b11000;
  localparam logic [4:0] OP_SRL  = 5'b11100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_ANDI = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BEQ  = 5'b10010;
  localparam logic [4:0] OP_BNE  = 5'b10110;
  localparam logic [4:0] OP_LW   = 5'b11010;
  localparam logic [4:0] OP_SW   = 5'b11110;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_JAL  = 5'b00101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
  } ctrl_t;

  // ALU register-register ops only; jr is R-format but never reaches EXEC.
  function automatic logic is_rtype(input logic [4:0] op);
    case (op)
      OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR, OP_SLL, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_itype(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_ANDI, OP_SUBI, OP_ORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [4:0] op);
    case (op)
      OP_AND, OP_ANDI: return ALU_AND;
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_OR,  OP_ORI:  return ALU_OR;
      OP_XOR:          return ALU_XOR;
      OP_SLL:          return ALU_SLL;
      OP_SRL:          return ALU_SRL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and the CORG datapath: IR opcode,
// ALU flag and memory handshake in; datapath enables, trap flags and debug state out.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 5,
  parameter int ALU_OP_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                reg_dst;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_write;
  logic                mem_to_reg;
  logic                link;
  logic                illegal;
  logic                timeout;
  logic [2:0]          state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_dst, alu_src,
           alu_op, reg_write, mem_to_reg, link, illegal, timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_dst, alu_src,
           alu_op, reg_write, mem_to_reg, link, illegal, timeout, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the wait budget is spent.
// WAIT_LIMIT = 0 turns the timer off (expired never asserts).
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: a default assignment first in every combinational block means no path leaves it unassigned, so no latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignment so every register samples its pre-edge inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (WAIT_LIMIT != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencing FSM for the CORG datapath: steps each instruction through
// fetch/decode/execute/memory/write-back and drives the shared datapath enables.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W        = 5,
  parameter int ALU_OP_W        = 3,
  parameter int WAIT_LIMIT      = 15,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);
  state_e              state_q, state_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [OPCODE_W-1:0] opcode;
  logic [4:0]          op;
  logic                op_hi;
  logic                is_r, is_i, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;
  logic                in_wait, expired;
  ctrl_t               ctrl_c, ctrl_o;

  assign opcode = bus.opcode;
  assign op     = opcode[4:0];
  // Any set bit above the decoded field makes the whole opcode illegal.
  assign op_hi  = (opcode >> 5) != '0;

  assign is_r   = !op_hi && is_rtype(op);
  assign is_i   = !op_hi && is_itype(op);
  assign is_j   = !op_hi && (op == OP_J);
  assign is_jal = !op_hi && (op == OP_JAL);
  assign is_jr  = !op_hi && (op == OP_JR);
  assign is_beq = !op_hi && (op == OP_BEQ);
  assign is_bne = !op_hi && (op == OP_BNE);
  assign is_lw  = !op_hi && (op == OP_LW);
  assign is_sw  = !op_hi && (op == OP_SW);

  // Count only while a request is outstanding; any non-wait state or a completed
  // request leaves the counter at zero for the next FETCH/MEM entry.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_wait || bus.mem_ready),
    .en_i     (in_wait && !bus.mem_ready),
    .expired_o(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (bus.mem_ready) begin
          if (state_q == S_FETCH) state_d = S_DECODE;
          else                    state_d = is_sw ? S_FETCH : S_WB;
        end else if (expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal || is_jr)  state_d = S_FETCH;
        else if (is_r || is_i)        state_d = S_EXEC;
        else if (is_beq || is_bne)    state_d = S_BRANCH;
        else if (is_lw || is_sw)      state_d = S_ADDR;
        else if (TRAP_ON_ILLEGAL != 0) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDR:   state_d = S_MEM;
      S_TRAP:   state_d = S_TRAP;
    endcase
  end

  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_PLUS1;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          ctrl_c.pc_write  = 1'b1;
          ctrl_c.pc_src    = PC_JUMP;
          ctrl_c.reg_write = is_jal;
          ctrl_c.link      = is_jal;
        end else if (is_jr) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_RS;
        end
      end
      S_EXEC: begin
        ctrl_c.alu_op  = alu_code(op);
        ctrl_c.alu_src = is_i;
      end
      S_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = is_r;
        ctrl_c.mem_to_reg = is_lw;
      end
      S_BRANCH: begin
        ctrl_c.alu_op   = ALU_SUB;
        ctrl_c.pc_src   = PC_BRANCH;
        ctrl_c.pc_write = is_beq ? bus.zero : (is_bne && !bus.zero);
      end
      S_ADDR: begin
        ctrl_c.alu_op  = ALU_ADD;
        ctrl_c.alu_src = 1'b1;
      end
      S_MEM: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
        ctrl_c.mem_we  = is_sw;
      end
      S_TRAP: ctrl_c = '0;
    endcase
  end

  // Reset forces every output low at once, abandoning any in-flight memory request.
  assign ctrl_o = rst ? '0 : ctrl_c;

  assign bus.mem_req    = ctrl_o.mem_req;
  assign bus.mem_we     = ctrl_o.mem_we;
  assign bus.iord       = ctrl_o.iord;
  assign bus.ir_write   = ctrl_o.ir_write;
  assign bus.pc_write   = ctrl_o.pc_write;
  assign bus.pc_src     = ctrl_o.pc_src;
  assign bus.reg_dst    = ctrl_o.reg_dst;
  assign bus.alu_src    = ctrl_o.alu_src;
  assign bus.alu_op     = ALU_OP_W'(ctrl_o.alu_op);
  assign bus.reg_write  = ctrl_o.reg_write;
  assign bus.mem_to_reg = ctrl_o.mem_to_reg;
  assign bus.link       = ctrl_o.link;
  assign bus.illegal    = !rst && illegal_q;
  assign bus.timeout    = !rst && timeout_q;
  assign bus.state      = rst ? 3'd0 : state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected outputs are queued
// with the stimulus and compared against the DUT at the falling edge.
module tb_multicycle_control_unit;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_BRANCH = 3'd4;
  localparam logic [2:0] ST_ADDR   = 3'd5;
  localparam logic [2:0] ST_MEM    = 3'd6;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic       illegal;
    logic       timeout;
    logic [2:0] state;
  } obs_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    obs_t       exp;
  } step_t;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] alu;
    logic       imm;
  } alu_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: short wait budget, traps on illegal. Instance B: 6-bit opcode, retires illegal as NOP.
  multicycle_control_unit_if #(.OPCODE_W(5), .ALU_OP_W(3)) ifa ();
  multicycle_control_unit_if #(.OPCODE_W(6), .ALU_OP_W(3)) ifb ();

  multicycle_control_unit #(
    .OPCODE_W(5), .ALU_OP_W(3), .WAIT_LIMIT(4), .TRAP_ON_ILLEGAL(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  multicycle_control_unit #(
    .OPCODE_W(6), .ALU_OP_W(3), .WAIT_LIMIT(15), .TRAP_ON_ILLEGAL(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.mem_req, ifa.mem_we, ifa.iord, ifa.ir_write, ifa.pc_write, ifa.pc_src,
                  ifa.reg_dst, ifa.alu_src, ifa.alu_op, ifa.reg_write, ifa.mem_to_reg,
                  ifa.link, ifa.illegal, ifa.timeout, ifa.state};
  assign obs_b = {ifb.mem_req, ifb.mem_we, ifb.iord, ifb.ir_write, ifb.pc_write, ifb.pc_src,
                  ifb.reg_dst, ifb.alu_src, ifb.alu_op, ifb.reg_write, ifb.mem_to_reg,
                  ifb.link, ifb.illegal, ifb.timeout, ifb.state};

  step_t      sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [5:0] cur_op = '0;
  logic       cur_z  = 1'b0;

  function automatic obs_t o_st(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  task automatic push(input logic rdy, input obs_t e);
    step_t s;
    s.opcode    = cur_op;
    s.mem_ready = rdy;
    s.zero      = cur_z;
    s.exp       = e;
    sb.push_back(s);
  endtask

  task automatic push_fetch(input int waits);
    obs_t e;
    for (int i = 0; i < waits; i++) begin
      e = o_st(ST_FETCH);
      e.mem_req = 1'b1;
      push(1'b0, e);
    end
    e = o_st(ST_FETCH);
    e.mem_req  = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    push(1'b1, e);
  endtask

  task automatic push_mem_wait(input int waits, input logic we);
    obs_t e;
    for (int i = 0; i < waits; i++) begin
      e = o_st(ST_MEM);
      e.mem_req = 1'b1;
      e.iord    = 1'b1;
      e.mem_we  = we;
      push(1'b0, e);
    end
  endtask

  task automatic push_mem(input int waits, input logic we);
    obs_t e;
    push_mem_wait(waits, we);
    e = o_st(ST_MEM);
    e.mem_req = 1'b1;
    e.iord    = 1'b1;
    e.mem_we  = we;
    push(1'b1, e);
  endtask

  task automatic push_addr;
    obs_t e;
    e = o_st(ST_ADDR);
    e.alu_src = 1'b1;
    push(1'b0, e);
  endtask

  task automatic drive(input logic [5:0] opc, input logic rdy, input logic z);
    ifa.opcode    = opc[4:0];
    ifb.opcode    = opc;
    ifa.mem_ready = rdy;
    ifb.mem_ready = rdy;
    ifa.zero      = z;
    ifb.zero      = z;
  endtask

  // Drains the scoreboard one clock per entry; called at posedge+1.
  task automatic run_sb(input bit on_b, input string name);
    step_t s;
    obs_t  got;
    int    cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      drive(s.opcode, s.mem_ready, s.zero);
      @(negedge clk);
      got = on_b ? obs_b : obs_a;
      total++;
      if (got !== s.exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h expected %h (state got %0d want %0d)",
                 name, cyc, got, s.exp, got.state, s.exp.state);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    obs_t e;
    drive(6'b000000, 1'b1, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs_a !== '0) begin
        bad++;
        $display("FAIL reset_a: got %h expected 0", obs_a);
      end
      total++;
      if (obs_b !== '0) begin
        bad++;
        $display("FAIL reset_b: got %h expected 0", obs_b);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_op = 6'b000000;
    e = o_st(ST_FETCH);
    e.mem_req = 1'b1;
    push(1'b0, e);
    run_sb(1'b0, "first_fetch");
  endtask

  task automatic test_alu_back_to_back;
    alu_vec_t tbl [11];
    obs_t     e;
    tbl = '{'{5'b00000, 3'b000, 1'b0}, '{5'b00100, 3'b001, 1'b0}, '{5'b01000, 3'b010, 1'b0},
            '{5'b01100, 3'b011, 1'b0}, '{5'b10000, 3'b100, 1'b0}, '{5'b11000, 3'b110, 1'b0},
            '{5'b11100, 3'b111, 1'b0}, '{5'b00010, 3'b000, 1'b1}, '{5'b00110, 3'b001, 1'b1},
            '{5'b01010, 3'b010, 1'b1}, '{5'b01110, 3'b011, 1'b1}};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      cur_op = {1'b0, tbl[i].op};
      cur_z  = i[0];
      push_fetch(i % 3);
      push(1'b1, o_st(ST_DECODE));
      e = o_st(ST_EXEC);
      e.alu_op  = tbl[i].alu;
      e.alu_src = tbl[i].imm;
      push(1'b0, e);
      e = o_st(ST_WB);
      e.reg_write = 1'b1;
      e.reg_dst   = !tbl[i].imm;
      push(1'b1, e);
    end
    run_sb(1'b0, "alu");
  endtask

  task automatic test_load_store;
    obs_t e;
    apply_reset();
    cur_z  = 1'b0;
    cur_op = 6'b011010;
    push_fetch(0);
    push(1'b0, o_st(ST_DECODE));
    push_addr();
    push_mem(3, 1'b0);
    e = o_st(ST_WB);
    e.reg_write  = 1'b1;
    e.mem_to_reg = 1'b1;
    push(1'b0, e);
    cur_op = 6'b011110;
    push_fetch(2);
    push(1'b0, o_st(ST_DECODE));
    push_addr();
    push_mem(1, 1'b1);
    cur_op = 6'b011010;
    push_fetch(0);
    push(1'b0, o_st(ST_DECODE));
    push_addr();
    push_mem(0, 1'b0);
    e = o_st(ST_WB);
    e.reg_write  = 1'b1;
    e.mem_to_reg = 1'b1;
    push(1'b1, e);
    run_sb(1'b0, "load_store");
  endtask

  task automatic test_branch;
    obs_t e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cur_op = (i < 2) ? 6'b010010 : 6'b010110;
      cur_z  = i[0];
      push_fetch(0);
      push(1'b1, o_st(ST_DECODE));
      e = o_st(ST_BRANCH);
      e.alu_op   = 3'b010;
      e.pc_src   = 2'b01;
      e.pc_write = (i < 2) ? cur_z : !cur_z;
      push(1'b1, e);
    end
    run_sb(1'b0, "branch");
  endtask

  task automatic test_jumps;
    obs_t e;
    apply_reset();
    cur_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_op = (i == 0) ? 6'b000001 : (i == 1) ? 6'b000101 : 6'b010101;
      push_fetch(0);
      e = o_st(ST_DECODE);
      e.pc_write  = 1'b1;
      e.pc_src    = (i == 2) ? 2'b11 : 2'b10;
      e.reg_write = (i == 1);
      e.link      = (i == 1);
      push(1'b1, e);
    end
    e = o_st(ST_FETCH);
    e.mem_req = 1'b1;
    push(1'b0, e);
    run_sb(1'b0, "jumps");
  endtask

  task automatic test_illegal_trap;
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      cur_op = (k == 0) ? 6'b000011 : 6'b011111;
      push_fetch(0);
      push(1'b1, o_st(ST_DECODE));
      for (int i = 0; i < 3; i++) begin
        e = o_st(ST_TRAP);
        e.illegal = 1'b1;
        push(i[0], e);
      end
      run_sb(1'b0, "illegal_trap");
    end
  endtask

  task automatic test_illegal_nop;
    obs_t e;
    apply_reset();
    cur_z = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cur_op = (k == 0) ? 6'b000011 : (k == 1) ? 6'b100000 : 6'b111010;
      push_fetch(0);
      push(1'b1, o_st(ST_DECODE));
    end
    cur_op = 6'b000000;
    push_fetch(1);
    push(1'b0, o_st(ST_DECODE));
    push(1'b0, o_st(ST_EXEC));
    e = o_st(ST_WB);
    e.reg_write = 1'b1;
    e.reg_dst   = 1'b1;
    push(1'b0, e);
    e = o_st(ST_FETCH);
    e.mem_req = 1'b1;
    push(1'b0, e);
    run_sb(1'b1, "illegal_nop");
  endtask

  task automatic check_async_reset(input string name);
    rst = 1'b1;
    #1;
    total++;
    if (obs_a !== '0) begin
      bad++;
      $display("FAIL %s: got %h expected 0 right after rst", name, obs_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_timeout;
    obs_t e;
    apply_reset();
    cur_op = 6'b000000;
    cur_z  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = o_st(ST_FETCH);
      e.mem_req = 1'b1;
      push(1'b0, e);
    end
    for (int i = 0; i < 2; i++) begin
      e = o_st(ST_TRAP);
      e.timeout = 1'b1;
      push(1'b1, e);
    end
    run_sb(1'b0, "fetch_timeout");
    check_async_reset("reset_clears_timeout");

    cur_op = 6'b011010;
    push_fetch(4);
    push(1'b0, o_st(ST_DECODE));
    push_addr();
    push_mem_wait(2, 1'b0);
    run_sb(1'b0, "lw_wait");
    ifa.mem_ready = 1'b0;
    check_async_reset("reset_mid_mem");

    cur_op = 6'b011110;
    push_fetch(0);
    push(1'b0, o_st(ST_DECODE));
    push_addr();
    push_mem_wait(5, 1'b1);
    e = o_st(ST_TRAP);
    e.timeout = 1'b1;
    push(1'b0, e);
    run_sb(1'b0, "mem_timeout");
  endtask

  initial begin
    drive(6'b000000, 1'b0, 1'b0);
    test_reset();
    test_alu_back_to_back();
    test_load_store();
    test_branch();
    test_jumps();
    test_illegal_trap();
    test_illegal_nop();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
